// File: rtl/esp8266_tx_sched_if.sv
// Command-stream and byte-transmitter handshake bundle for esp8266_tx_sched.
// The master side is the scheduler; the slave side is the command source plus uart_byte_tx.
interface esp8266_tx_sched_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic       cmd_ready;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        input  cmd_valid, cmd_data, cmd_last, tx_done,
        output cmd_ready, tx_en, tx_data
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_last, tx_done,
        input  cmd_ready, tx_en, tx_data
    );
endinterface

// File: rtl/esp8266_tx_sched.sv
// Shares one uart_byte_tx between a periodic telemetry frame (header, d1..d4, xor)
// and a command byte stream, arbitrating round-robin only at frame boundaries.
module esp8266_tx_sched #(
    parameter int          PERIOD = 5000000,
    parameter logic [31:0] HEADER = 32'hFFFEFDFC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    esp8266_tx_sched_if.master        link,
    input  logic                      tele_en,
    input  logic [7:0]                d1,
    input  logic [7:0]                d2,
    input  logic [7:0]                d3,
    input  logic [7:0]                d4,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      frame_src,
    output logic                      tele_overrun
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          tele_pending;
    logic          last_src;
    logic [3:0]    idx;
    logic [31:0]   payload;
    logic [7:0]    xor_r;
    logic          cmd_last_r;
    logic [7:0]    tx_data_r;

    logic          grant;
    logic          grant_src;
    logic          tx_en_c;
    logic          cmd_ready_c;
    logic [7:0]    launch_byte;
    logic [7:0]    t_byte;
    logic          is_last;
    logic          finish;

    assign tick = tele_en && (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!tele_en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        t_byte = 8'h00;
        case (idx)
            4'd0:    t_byte = HEADER[31:24];
            4'd1:    t_byte = HEADER[23:16];
            4'd2:    t_byte = HEADER[15:8];
            4'd3:    t_byte = HEADER[7:0];
            4'd4:    t_byte = payload[31:24];
            4'd5:    t_byte = payload[23:16];
            4'd6:    t_byte = payload[15:8];
            4'd7:    t_byte = payload[7:0];
            4'd8:    t_byte = xor_r;
            default: t_byte = 8'h00;
        endcase
    end

    assign is_last = frame_src ? cmd_last_r : (idx == 4'd8);
    assign finish  = (state == WAIT) && link.tx_done && is_last;

    // A command grant stays in LAUNCH until the source supplies a byte, so frames never interleave.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_src   = last_src;
        tx_en_c     = 1'b0;
        cmd_ready_c = 1'b0;
        launch_byte = 8'h00;
        case (state)
            IDLE: begin
                if (tele_pending && link.cmd_valid) begin
                    grant     = 1'b1;
                    grant_src = ~last_src;
                end else if (tele_pending) begin
                    grant     = 1'b1;
                    grant_src = 1'b0;
                end else if (link.cmd_valid) begin
                    grant     = 1'b1;
                    grant_src = 1'b1;
                end
                if (grant) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!frame_src) begin
                    tx_en_c     = 1'b1;
                    launch_byte = t_byte;
                    state_next  = WAIT;
                end else if (link.cmd_valid) begin
                    tx_en_c     = 1'b1;
                    cmd_ready_c = 1'b1;
                    launch_byte = link.cmd_data;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (link.tx_done) begin
                    state_next = is_last ? IDLE : LAUNCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tele_pending <= 1'b0;
            last_src     <= 1'b1;
            idx          <= 4'd0;
            payload      <= 32'h0;
            xor_r        <= 8'h00;
            cmd_last_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_src    <= 1'b0;
            tele_overrun <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done   <= finish;
            // A tick coinciding with a telemetry grant re-arms pending instead of overrunning.
            tele_overrun <= tick && tele_pending && !(grant && !grant_src);
            if (tick) begin
                tele_pending <= 1'b1;
            end else if (grant && !grant_src) begin
                tele_pending <= 1'b0;
            end
            if (grant) begin
                busy      <= 1'b1;
                frame_src <= grant_src;
                last_src  <= grant_src;
                idx       <= 4'd0;
                if (!grant_src) begin
                    payload <= {d1, d2, d3, d4};
                    xor_r   <= d1 ^ d2 ^ d3 ^ d4;
                end
            end
            if (tx_en_c) begin
                tx_data_r <= launch_byte;
                if (frame_src) begin
                    cmd_last_r <= link.cmd_last;
                end
            end
            if ((state == WAIT) && link.tx_done) begin
                if (is_last) begin
                    busy <= 1'b0;
                    idx  <= 4'd0;
                end else if (!frame_src) begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    assign link.tx_en     = tx_en_c;
    assign link.cmd_ready = cmd_ready_c;
    assign link.tx_data   = tx_en_c ? launch_byte : tx_data_r;

endmodule

// File: tb/tb_esp8266_tx_sched.sv
// Self-checking bench for esp8266_tx_sched: expected bytes and frame sources are queued
// per scenario and compared as the scheduler launches bytes and completes frames.
module tb_esp8266_tx_sched;

    localparam int PERIOD = 16;

    logic       clk;
    logic       rst_n;
    logic       tele_en;
    logic [7:0] d1, d2, d3, d4;
    logic       busy, frame_done, frame_src, tele_overrun;

    esp8266_tx_sched_if bus();

    esp8266_tx_sched #(.PERIOD(PERIOD), .HEADER(32'hFFFEFDFC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link         (bus),
        .tele_en      (tele_en),
        .d1           (d1),
        .d2           (d2),
        .d3           (d3),
        .d4           (d4),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_src    (frame_src),
        .tele_overrun (tele_overrun)
    );

    typedef struct {
        logic [7:0] d1, d2, d3, d4;
        logic [7:0] xr;
        int         delay;
    } tvec_t;

    tvec_t      vecs [4];
    logic [7:0] cmd_buf [4];
    logic [7:0] exp_q [$];
    logic       src_q [$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc;
    int   done_delay = 20;
    int   done_cnt = 0;
    bit   stray_req = 0;
    int   tx_cnt, frame_cnt, ovr_cnt, cmd_ready_cnt, first_tx_cyc;
    logic [7:0] last_byte;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor and byte-transmitter model, sampled just before each rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            done_cnt    = 0;
            bus.tx_done = 1'b0;
        end else begin
            bus.tx_done = 1'b0;
            if (stray_req) begin
                bus.tx_done = 1'b1;
                stray_req   = 0;
            end
            if (done_cnt > 0) begin
                if (done_cnt == 1) begin
                    bus.tx_done = 1'b1;
                    check_output("tx_data_hold", bus.tx_data, last_byte);
                    check_output("tx_en_low_in_wait", bus.tx_en, 0);
                end
                done_cnt--;
            end
            if (bus.tx_en) begin
                tx_cnt++;
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                check_output("tx_en_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_output("tx_byte", bus.tx_data, exp_q.pop_front());
                check_output("busy_at_tx_en", busy, 1);
                last_byte = bus.tx_data;
                done_cnt  = done_delay;
            end
            if (bus.cmd_ready) begin
                cmd_ready_cnt++;
                check_output("cmd_ready_with_tx_en", bus.tx_en, 1);
            end
            if (frame_done) begin
                frame_cnt++;
                check_output("frame_done_expected", int'(src_q.size() > 0), 1);
                if (src_q.size() > 0) check_output("frame_src", frame_src, src_q.pop_front());
                check_output("busy_after_frame", busy, 0);
            end
            if (tele_overrun) ovr_cnt++;
        end
    end

    task automatic push_t_frame(input logic [7:0] a, b, c, d, xr);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFD);
        exp_q.push_back(8'hFC);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(xr);
        src_q.push_back(1'b0);
    endtask

    task automatic push_c_frame();
        for (int i = 0; i < 4; i++) exp_q.push_back(cmd_buf[i]);
        src_q.push_back(1'b1);
    endtask

    task automatic do_reset(input bit tele);
        @(negedge clk);
        rst_n         = 1'b0;
        tele_en       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
        stray_req     = 0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        src_q.delete();
        tx_cnt = 0; frame_cnt = 0; ovr_cnt = 0; cmd_ready_cnt = 0; first_tx_cyc = -1;
        rst_n   = 1'b1;
        tele_en = tele;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("frame_count", frame_cnt, target);
    endtask

    // Offers cmd_buf as one frame; optionally drops cmd_valid for gap_len cycles before byte gap_after.
    task automatic send_cmd(input int gap_after, input int gap_len, input bit tele_gap);
        for (int i = 0; i < 4; i++) begin
            int target;
            int n;
            if (i == gap_after && gap_len > 0) begin
                bus.cmd_valid = 1'b0;
                if (tele_gap) tele_en = 1'b1;
                for (int g = 0; g < gap_len; g++) begin
                    if (g == 20) tele_en = 1'b0;
                    if (g == 25) begin
                        check_output("grant_held_busy", busy, 1);
                        check_output("grant_held_src", frame_src, 1);
                    end
                    @(negedge clk);
                end
            end
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = cmd_buf[i];
            bus.cmd_last  = (i == 3);
            target = cmd_ready_cnt + 1;
            n = 0;
            while (cmd_ready_cnt < target && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check_output("cmd_byte_taken", int'(cmd_ready_cnt >= target), 1);
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input tvec_t v);
        d1 = v.d1; d2 = v.d2; d3 = v.d3; d4 = v.d4;
        done_delay = v.delay;
        do_reset(1'b1);
        push_t_frame(v.d1, v.d2, v.d3, v.d4, v.xr);
        wait_cyc(17);
        tele_en = 1'b0;
        d1 = ~v.d1; d2 = ~v.d2; d3 = ~v.d3; d4 = ~v.d4;
        wait_frames(1, 2000);
        repeat (40) @(negedge clk);
        // Tick in cycle PERIOD-1, pending visible and granted in PERIOD, launched in PERIOD+1.
        check_output("first_tx_cycle", first_tx_cyc, PERIOD + 1);
        check_output("t_tx_count", tx_cnt, 9);
        check_output("t_queue_empty", exp_q.size(), 0);
        check_output("t_no_overrun", ovr_cnt, 0);
        check_output("t_no_cmd_ready", cmd_ready_cnt, 0);
    endtask

    initial begin
        vecs[0] = '{d1: 8'h12, d2: 8'h34, d3: 8'h56, d4: 8'h78, xr: 8'h08, delay: 20};
        vecs[1] = '{d1: 8'h01, d2: 8'h02, d3: 8'h03, d4: 8'h04, xr: 8'h04, delay: 3};
        vecs[2] = '{d1: 8'hFF, d2: 8'h00, d3: 8'hAA, d4: 8'h55, xr: 8'h00, delay: 1};
        vecs[3] = '{d1: 8'h80, d2: 8'h40, d3: 8'h20, d4: 8'h10, xr: 8'hF0, delay: 7};
        cmd_buf = '{8'h41, 8'h54, 8'h0D, 8'h0A};

        rst_n = 1'b0; tele_en = 1'b0;
        d1 = 8'h0; d2 = 8'h0; d3 = 8'h0; d4 = 8'h0;
        bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.cmd_last = 1'b0; bus.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_tx_en", bus.tx_en, 0);
        check_output("reset_tx_data", bus.tx_data, 0);
        check_output("reset_cmd_ready", bus.cmd_ready, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_frame_done", frame_done, 0);
        check_output("reset_frame_src", frame_src, 0);
        check_output("reset_overrun", tele_overrun, 0);

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        $display("[TB] command frame alone");
        done_delay = 5;
        do_reset(1'b0);
        push_c_frame();
        wait_cyc(5);
        send_cmd(4, 0, 1'b0);
        wait_frames(1, 1000);
        repeat (40) @(negedge clk);
        check_output("c_cmd_ready_count", cmd_ready_cnt, 4);
        check_output("c_tx_count", tx_cnt, 4);
        check_output("c_queue_empty", exp_q.size(), 0);

        $display("[TB] tie right after reset: telemetry first");
        done_delay = 6;
        d1 = 8'hA1; d2 = 8'hB2; d3 = 8'hC3; d4 = 8'hD4;
        do_reset(1'b1);
        push_t_frame(d1, d2, d3, d4, d1 ^ d2 ^ d3 ^ d4);
        push_c_frame();
        wait_cyc(16);
        fork
            send_cmd(4, 0, 1'b0);
            begin
                wait_cyc(17);
                tele_en = 1'b0;
            end
        join
        wait_frames(2, 2000);
        repeat (40) @(negedge clk);
        check_output("tie_queue_empty", exp_q.size(), 0);

        $display("[TB] tie after a telemetry frame: command first");
        done_delay = 20;
        d1 = 8'h0A; d2 = 8'h0B; d3 = 8'h0C; d4 = 8'h0D;
        do_reset(1'b1);
        push_t_frame(d1, d2, d3, d4, d1 ^ d2 ^ d3 ^ d4);
        push_c_frame();
        push_t_frame(d1, d2, d3, d4, d1 ^ d2 ^ d3 ^ d4);
        wait_cyc(40);
        tele_en = 1'b0;
        wait_cyc(50);
        send_cmd(4, 0, 1'b0);
        wait_frames(3, 3000);
        repeat (40) @(negedge clk);
        check_output("rr_queue_empty", exp_q.size(), 0);
        check_output("rr_no_overrun", ovr_cnt, 0);

        $display("[TB] command gap with tick: grant held");
        done_delay = 20;
        d1 = 8'h5A; d2 = 8'h3C; d3 = 8'h99; d4 = 8'h01;
        do_reset(1'b0);
        push_c_frame();
        push_t_frame(d1, d2, d3, d4, d1 ^ d2 ^ d3 ^ d4);
        wait_cyc(3);
        send_cmd(2, 50, 1'b1);
        wait_frames(2, 3000);
        repeat (40) @(negedge clk);
        check_output("gap_queue_empty", exp_q.size(), 0);
        check_output("gap_tx_count", tx_cnt, 13);

        $display("[TB] slow transmitter: overruns");
        done_delay = 40;
        d1 = 8'h11; d2 = 8'h22; d3 = 8'h44; d4 = 8'h88;
        do_reset(1'b1);
        push_t_frame(d1, d2, d3, d4, 8'hFF);
        push_t_frame(d1, d2, d3, d4, 8'hFF);
        wait_cyc(72);
        tele_en = 1'b0;
        wait_frames(2, 3000);
        repeat (60) @(negedge clk);
        check_output("overrun_count", ovr_cnt, 2);
        check_output("overrun_tx_count", tx_cnt, 18);
        check_output("overrun_queue_empty", exp_q.size(), 0);

        $display("[TB] stray tx_done while idle");
        do_reset(1'b0);
        wait_cyc(3);
        stray_req = 1;
        repeat (20) @(negedge clk);
        check_output("stray_tx_count", tx_cnt, 0);
        check_output("stray_frame_count", frame_cnt, 0);
        check_output("stray_busy", busy, 0);

        $display("[TB] reset mid-frame");
        done_delay = 10;
        d1 = 8'h12; d2 = 8'h34; d3 = 8'h56; d4 = 8'h78;
        do_reset(1'b1);
        push_t_frame(d1, d2, d3, d4, 8'h08);
        begin
            int n = 0;
            while (tx_cnt < 3 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check_output("midreset_progress", int'(tx_cnt >= 3), 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midreset_tx_en", bus.tx_en, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_frame_done", frame_done, 0);
        do_reset(1'b0);
        repeat (100) @(negedge clk);
        check_output("midreset_no_resume", tx_cnt, 0);
        check_output("midreset_no_frame", frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
